// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: baud divisors shared with uart_tx.
// Clock cycles per bit at a 12 MHz system clock.
package uart_rx_pkg;

  localparam int B9600   = 1250;
  localparam int B19200  = 625;
  localparam int B38400  = 312;
  localparam int B57600  = 208;
  localparam int B115200 = 104;
  localparam int B230400 = 52;
  localparam int B460800 = 26;

  typedef logic [7:0] uart_byte_t;

  // counter reload that lands on the middle of the start bit
  function automatic int half_reload(input int baud);
    return baud / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte handshake plus error pulses.
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  import uart_rx_pkg::*;

  uart_byte_t data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchronizer for an async input.
// Both stages take RST_VAL on reset (idle level).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // shift the async input through two stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, ready/valid out.
// Bytes finishing while the holding reg is full are dropped.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAITH = 3'd4;

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF = CW'(half_reload(BAUDRATE));
  localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);

  logic          rxs;
  logic          rxs_prev_q, rxs_prev_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  uart_byte_t    shift_q, shift_d;
  logic          done_q, done_d;
  uart_byte_t    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          stop_hit;
  logic          take;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  assign tick     = (cnt_q == '0);
  assign stop_hit = (state_q == S_STOP) && tick;
  assign take     = valid_q && bus.ready;

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // next state: bit timing and shifting
  always_comb begin
    rxs_prev_d = rxs;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (rxs_prev_q && !rxs) begin
          state_d = S_START;
          cnt_d   = HALF;
        end
      end
      (state_q == S_START): begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs) begin
          state_d = S_DATA;
          cnt_d   = FULL;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      (state_q == S_DATA): begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      (state_q == S_STOP): begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = rxs ? S_IDLE : S_WAITH;
        end
      end
      (state_q == S_WAITH): begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs: delivery, handshake and error pulses
  always_comb begin
    done_d  = stop_hit && rxs;
    ferr_d  = stop_hit && !rxs;
    data_d  = data_q;
    valid_d = valid_q && !take;
    ovr_d   = 1'b0;
    if (done_q) begin
      if (!valid_q || take) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 104 clk/bit.
// Monitor samples on posedge, stimulus changes on negedge.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int B   = B115200;
  localparam int LAT = 2 + B / 2 + 9 * B + 1;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if u_if ();

  uart_rx #(.BAUDRATE(B)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (u_if.master)
  );

  int n_chk;
  int n_err;
  int cyc;
  int ferr_cnt;
  int ovr_cnt;
  int vrise;
  int vhi;
  int lat_t0;
  bit lat_arm;
  logic [7:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // caller must be at a negedge; returns at a negedge
  task automatic send_byte(input logic [7:0] b, input int per,
                           input logic stop);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  // monitor: pulse counters, latency, hold check, scoreboard pop
  initial begin
    bit pv;
    bit ptake;
    logic [7:0] pd;
    pv = 0;
    ptake = 0;
    pd = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pv = 0;
        ptake = 0;
      end else begin
        if (u_if.frame_err) ferr_cnt++;
        if (u_if.overrun) ovr_cnt++;
        if (u_if.valid) vhi++;
        if (u_if.valid && !pv) begin
          vrise++;
          if (lat_arm) begin
            lat_arm = 0;
            chk("latency", cyc - 1 - lat_t0, LAT);
          end
        end
        if (pv && !ptake) chk("hold", u_if.data, pd);
        if (u_if.valid && u_if.ready) begin
          if (sb.size() == 0) chk("sb_extra", sb.size(), 1);
          else chk("data", u_if.data, sb.pop_front());
        end
        pv = u_if.valid;
        ptake = u_if.valid && u_if.ready;
        pd = u_if.data;
      end
    end
  end

  initial begin
    int f0;
    int o0;
    int v0;
    int h0;
    rst = 1'b1;
    rx = 1'b1;
    u_if.ready = 1'b1;
    #1;
    chk("rst_data", u_if.data, 0);
    chk("rst_valid", u_if.valid, 0);
    chk("rst_ferr", u_if.frame_err, 0);
    chk("rst_ovr", u_if.overrun, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 0x55, ready high: latency, one-cycle valid
    f0 = ferr_cnt; o0 = ovr_cnt; h0 = vhi;
    sb.push_back(8'h55);
    lat_arm = 1;
    lat_t0 = cyc + 1;
    send_byte(8'h55, B, 1'b1);
    wait_drain();
    repeat (20) @(negedge clk);
    chk("t1_vcycles", vhi - h0, 1);
    chk("t1_ferr", ferr_cnt - f0, 0);
    chk("t1_ovr", ovr_cnt - o0, 0);
    chk("t1_latarm", lat_arm, 0);

    // ready low: 0xA5 held, 0x3C overruns
    u_if.ready = 1'b0;
    o0 = ovr_cnt; f0 = ferr_cnt;
    sb.push_back(8'hA5);
    send_byte(8'hA5, B, 1'b1);
    send_byte(8'h3C, B, 1'b1);
    repeat (200) @(negedge clk);
    chk("t2_ovr", ovr_cnt - o0, 1);
    chk("t2_valid", u_if.valid, 1);
    chk("t2_ferr", ferr_cnt - f0, 0);
    u_if.ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("t2_vclr", u_if.valid, 0);

    // bad stop then line low, then 0x42
    f0 = ferr_cnt; v0 = vrise;
    send_byte(8'h81, B, 1'b0);
    repeat (30 * B) @(negedge clk);
    chk("t3_ferr", ferr_cnt - f0, 1);
    chk("t3_novalid", vrise - v0, 0);
    rx = 1'b1;
    repeat (2 * B) @(negedge clk);
    sb.push_back(8'h42);
    send_byte(8'h42, B, 1'b1);
    wait_drain();

    // 20-clk glitch is rejected
    f0 = ferr_cnt; v0 = vrise;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("t4_novalid", vrise - v0, 0);
    chk("t4_noferr", ferr_cnt - f0, 0);

    // reset during data bit 4, then 0xF0
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (B) @(negedge clk);
    end
    rx = 1'b1;
    repeat (B / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_data", u_if.data, 0);
    chk("t5_valid", u_if.valid, 0);
    chk("t5_ferr", u_if.frame_err, 0);
    chk("t5_ovr", u_if.overrun, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    sb.push_back(8'hF0);
    send_byte(8'hF0, B, 1'b1);
    wait_drain();

    // back-to-back stream at skewed baud rates
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int p = 0; p < 2; p++) begin
      int per;
      int start;
      per = (p == 0) ? 102 : 106;
      start = (p == 0) ? 0 : 6;
      sb.push_back(8'h00);
      send_byte(8'h00, per, 1'b1);
      sb.push_back(8'hFF);
      send_byte(8'hFF, per, 1'b1);
      for (int i = start; i < 256; i += 13) begin
        sb.push_back(8'(i));
        send_byte(8'(i), per, 1'b1);
      end
      wait_drain();
    end
    chk("t6_ferr", ferr_cnt - f0, 0);
    chk("t6_ovr", ovr_cnt - o0, 0);

    repeat (20) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
